ps2_key_sequencer: RTL and testbench

- Sits between the PS/2 byte receiver and game/UI logic.
- Turns the raw scan-code byte stream into key events:
  - Decodes the E0 (extended) and F0 (break) prefix sequences.
  - Tracks held state for the left and right arrow keys.
  - Queues events in a small FIFO with a valid/ready handshake.
- Receiver errors and stalled prefix sequences are discarded cleanly.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_evt_fifo.sv | 51 +++++
 rtl/ps2_key_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code constants, sequencer states and key event type
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } seq_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - synchronous FIFO of key events, write accepted when full if a read frees a slot
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  key_evt_t wr_data,
    input  logic     rd_en,
    output key_evt_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    key_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_wr, do_rd;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - PS/2 scan-code prefix decoder, held-arrow tracking and event queue
// Optional PS2_TYPEMATIC_FILTER_EN: drop repeat makes of tracked keys while already held.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         PREFIX_TIMEOUT = 250000,
    parameter logic [7:0] LEFT_CODE      = SC_LEFT,
    parameter logic [7:0] RIGHT_CODE     = SC_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_error,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       held_left,
    output logic       held_right,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic [7:0] err_count
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(PREFIX_TIMEOUT - 1);

    seq_state_e    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok, is_prefix, gen, suppress;
    key_evt_t      gen_evt, push_evt_q, head;
    logic          push_q, pop, fifo_full, fifo_empty;
    logic          held_left_q, held_left_d, held_right_q, held_right_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_q, err_d;

    assign byte_ok   = rx_valid & ~rx_error;
    assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // An accepted byte always takes priority over a timeout in the same cycle.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        gen           = 1'b0;
        gen_evt.code  = rx_byte;
        gen_evt.ext   = 1'b0;
        gen_evt.rel   = 1'b0;
        if (rx_valid && rx_error) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else if (byte_ok) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT)      state_d = ST_EXT;
                    else if (rx_byte == SC_BRK) state_d = ST_BRK;
                    else                        gen = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_byte == SC_EXT) state_d = ST_EXT;
                    else begin
                        gen         = 1'b1;
                        gen_evt.ext = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    gen         = ~is_prefix;
                    gen_evt.rel = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: begin
                    gen         = ~is_prefix;
                    gen_evt.ext = 1'b1;
                    gen_evt.rel = 1'b1;
                    state_d     = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        held_left_d  = held_left_q;
        held_right_d = held_right_q;
        if (gen && rx_byte == LEFT_CODE)  held_left_d  = ~gen_evt.rel;
        if (gen && rx_byte == RIGHT_CODE) held_right_d = ~gen_evt.rel;
`ifdef PS2_TYPEMATIC_FILTER_EN
        suppress = ~gen_evt.rel &
                   (((rx_byte == LEFT_CODE) & held_left_q) |
                    ((rx_byte == RIGHT_CODE) & held_right_q));
`else
        suppress = 1'b0;
`endif
        ovf_d = ovf_q;
        if (ovf_clear)                        ovf_d = 1'b0;
        if (push_q && fifo_full && !pop)      ovf_d = 1'b1;
        err_d = err_q;
        if (rx_valid && rx_error && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_left_q  <= 1'b0;
            held_right_q <= 1'b0;
            push_q       <= 1'b0;
            push_evt_q   <= '0;
            ovf_q        <= 1'b0;
            err_q        <= '0;
        end else begin
            held_left_q  <= held_left_d;
            held_right_q <= held_right_d;
            push_q       <= gen & ~suppress;
            push_evt_q   <= gen_evt;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    assign pop = ~fifo_empty & evt_ready;

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (push_evt_q),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid   = ~fifo_empty;
    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_release = head.rel;
    assign held_left   = held_left_q;
    assign held_right  = held_right_q;
    assign overflow    = ovf_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb/tb_ps2_key_sequencer.sv - directed self-checking bench for ps2_key_sequencer
module tb_ps2_key_sequencer;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_error = 1'b0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       held_left;
    logic       held_right;
    logic       overflow;
    logic       ovf_clear = 1'b0;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    ps2_key_sequencer #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_release(evt_release), .held_left(held_left), .held_right(held_right),
        .overflow(overflow), .ovf_clear(ovf_clear), .err_count(err_count)
    );

    // Inputs change 2ns after posedge, so negedge sees exactly what the next posedge will act on.
    always @(negedge clk)
        if (evt_valid && evt_ready) got_q.push_back({evt_code, evt_ext, evt_release});

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_error = err;
        cyc(1);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({evt_valid, held_left, held_right, overflow, err_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000", {evt_valid, held_left, held_right, overflow, err_count});
        end
    endtask

    task automatic test_basic;
        got_q.delete();
        evt_ready = 1'b0;
        send(8'h6B, 1'b0);
        checks++;
        if (held_left !== 1'b1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1 held_left=%b evt_valid=%b want 1 0", held_left, evt_valid);
        end
        cyc(1);
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency2 evt_valid=%b want 1", evt_valid);
        end
        evt_ready = 1'b1;
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        cyc(4);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {8'h6B, 2'b00} || got_q[1] !== {8'h6B, 2'b11}) begin
            errors++;
            $display("FAIL basic_events n=%0d first=%h second=%h want 2 1ac 1af", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 10'h0, got_q.size() > 1 ? got_q[1] : 10'h0);
        end
        checks++;
        if (held_left !== 1'b0) begin
            errors++;
            $display("FAIL basic_held_release held_left=%b want 0", held_left);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        got_q.delete();
        evt_ready = 1'b0;
        send(8'hE0, 1'b0);
        send(8'h74, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (evt_valid !== 1'b1 || evt_code !== 8'h74 || evt_ext !== 1'b1 || evt_release !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_stable bad_cycles=%0d want 0 (code=%h ext=%b)", bad, evt_code, evt_ext);
        end
        checks++;
        if (held_right !== 1'b1) begin
            errors++;
            $display("FAIL stall_held_right held_right=%b want 1", held_right);
        end
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        cyc(2);
        checks++;
        if (got_q.size() != 1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_pop pops=%0d evt_valid=%b want 1 0", got_q.size(), evt_valid);
        end
    endtask

    task automatic test_timeout;
        got_q.delete();
        evt_ready = 1'b1;
        send(8'hE0, 1'b0);
        cyc(TMO + 4);
        send(8'h74, 1'b0);
        send(8'hE0, 1'b0);
        cyc(5);
        send(8'hF0, 1'b0);
        send(8'h74, 1'b0);
        cyc(4);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== {8'h74, 2'b00} || got_q[1] !== {8'h74, 2'b11}) begin
            errors++;
            $display("FAIL timeout_events n=%0d first=%h second=%h want 2 1d0 1d3", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 10'h0, got_q.size() > 1 ? got_q[1] : 10'h0);
        end
        checks++;
        if (held_right !== 1'b0) begin
            errors++;
            $display("FAIL timeout_held_right held_right=%b want 0", held_right);
        end
    endtask

    task automatic test_frame_error;
        got_q.delete();
        evt_ready = 1'b1;
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b1);
        cyc(4);
        checks++;
        if (got_q.size() != 0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL error_discard events=%0d err_count=%0d want 0 1", got_q.size(), err_count);
        end
        send(8'h6B, 1'b0);
        cyc(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {8'h6B, 2'b00} || held_left !== 1'b1) begin
            errors++;
            $display("FAIL error_recover n=%0d ev=%h held_left=%b want 1 1ac 1", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 10'h0, held_left);
        end
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        cyc(4);
    endtask

    task automatic test_overflow;
        logic [7:0] codes [6];
        codes = '{8'h6B, 8'h74, 8'h1C, 8'h32, 8'h21, 8'h2A};
        got_q.delete();
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(codes[i], 1'b0);
        cyc(3);
        checks++;
        if (overflow !== 1'b1 || evt_valid !== 1'b1 || held_left !== 1'b1 || held_right !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set overflow=%b evt_valid=%b held=%b%b want 1 1 11", overflow, evt_valid,
                     held_left, held_right);
        end
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear overflow=%b want 0", overflow);
        end
        send(8'h1B, 1'b0);
        ovf_clear = 1'b1;
        cyc(1);
        ovf_clear = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins overflow=%b want 1", overflow);
        end
        ovf_clear = 1'b1;
        evt_ready = 1'b1;
        cyc(8);
        ovf_clear = 1'b0;
        checks++;
        if (got_q.size() != 4 || got_q[0] !== {8'h6B, 2'b00} || got_q[3] !== {8'h32, 2'b00}) begin
            errors++;
            $display("FAIL ovf_drain n=%0d first=%h last=%h want 4 1ac 0c8", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 10'h0, got_q.size() > 3 ? got_q[3] : 10'h0);
        end
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h74, 1'b0);
        cyc(4);
        checks++;
        if (held_left !== 1'b0 || held_right !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_release held=%b%b overflow=%b want 00 0", held_left, held_right, overflow);
        end
    endtask

    task automatic test_back_to_back_full;
        got_q.delete();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
        send(8'h20, 1'b0);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        cyc(2);
        checks++;
        if (overflow !== 1'b0 || got_q.size() != 1 || evt_code !== 8'h11) begin
            errors++;
            $display("FAIL full_push_pop overflow=%b pops=%0d head=%h want 0 1 11", overflow, got_q.size(),
                     evt_code);
        end
        evt_ready = 1'b1;
        cyc(6);
        checks++;
        if (got_q.size() != 5 || got_q[4] !== {8'h20, 2'b00}) begin
            errors++;
            $display("FAIL full_push_pop_drain n=%0d last=%h want 5 080", got_q.size(),
                     got_q.size() > 4 ? got_q[4] : 10'h0);
        end
    endtask

    task automatic test_typematic;
        int want;
`ifdef PS2_TYPEMATIC_FILTER_EN
        want = 2;
`else
        want = 4;
`endif
        got_q.delete();
        evt_ready = 1'b1;
        send(8'h6B, 1'b0);
        send(8'h6B, 1'b0);
        send(8'h6B, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        cyc(5);
        checks++;
        if (got_q.size() != want || got_q[got_q.size()-1] !== {8'h6B, 2'b01}) begin
            errors++;
            $display("FAIL typematic n=%0d want %0d", got_q.size(), want);
        end
    endtask

    task automatic test_reset_mid;
        got_q.delete();
        evt_ready = 1'b1;
        send(8'h6B, 1'b0);
        send(8'hE0, 1'b0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        checks++;
        if (held_left !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_state held_left=%b err_count=%0d want 0 0", held_left, err_count);
        end
        got_q.delete();
        send(8'h74, 1'b0);
        cyc(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {8'h74, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_prefix n=%0d ev=%h want 1 1d0", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 10'h0);
        end
    endtask

    initial begin
        cyc(3);
        test_reset;
        rst = 1'b0;
        cyc(1);
        test_reset;
        test_basic;
        test_backpressure;
        test_timeout;
        test_frame_error;
        test_overflow;
        test_back_to_back_full;
        test_typematic;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
